// File: rtl/lsu_sram_port.sv
// Load/store initiator for the data port of the dual-read byte-enabled SRAM.
// Issues one CPU request at a time and returns an aligned, extended response.
module lsu_sram_port #(
  parameter int DEPTH      = 65536,
  parameter int DATA_WIDTH = 32,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_cen,
  output logic                  mem_wen,
  output logic [3:0]            mem_ben,
  output logic [AW-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] hold_rdata_q, hold_rdata_d;
  logic        hold_err_q, hold_err_d;

  logic        accept;
  logic        req_err;
  logic [31:0] addr_hi;
  logic [31:0] shifted;
  logic [31:0] fmt_rdata;

  // NOTE: req_ready is gated by rst_n so a request held valid during reset can
  // never pull mem_cen low; outside reset it depends on state only.
  assign req_ready = (state_q == IDLE) && rst_n;
  assign accept    = req_valid && req_ready;

  assign addr_hi = req_addr >> (AW + 2);
  always_comb begin
    req_err = 1'b0;
    if (req_size == 2'd3)                               req_err = 1'b1;
    if (req_size == SZ_HALF && req_addr[0])             req_err = 1'b1;
    if (req_size == SZ_WORD && req_addr[1:0] != 2'b00)  req_err = 1'b1;
    if (addr_hi != 32'd0)                               req_err = 1'b1;
  end

  // Align the captured SRAM word to the requested byte offset, then extend.
  assign shifted = mem_dout >> {off_q, 3'b000};
  always_comb begin
    fmt_rdata = 32'd0;
    if (!we_q) begin
      case (size_q)
        SZ_BYTE: fmt_rdata = uns_q ? {24'd0, shifted[7:0]}
                                   : {{24{shifted[7]}}, shifted[7:0]};
        SZ_HALF: fmt_rdata = uns_q ? {16'd0, shifted[15:0]}
                                   : {{16{shifted[15]}}, shifted[15:0]};
        default: fmt_rdata = shifted;
      endcase
    end
  end

  // NOTE: all state updates use non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      size_q       <= 2'd0;
      uns_q        <= 1'b0;
      off_q        <= 2'd0;
      hold_rdata_q <= 32'd0;
      hold_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      off_q        <= off_d;
      hold_rdata_q <= hold_rdata_d;
      hold_err_q   <= hold_err_d;
    end
  end

  // NOTE: every always_comb output is given a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = req_err ? HOLD : ACC;
      ACC:     state_d = rsp_ready ? IDLE : HOLD;
      HOLD:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    we_d         = we_q;
    size_d       = size_q;
    uns_d        = uns_q;
    off_d        = off_q;
    hold_rdata_d = hold_rdata_q;
    hold_err_d   = hold_err_q;
    if (accept) begin
      we_d   = req_we;
      size_d = req_size;
      uns_d  = req_unsigned;
      off_d  = req_addr[1:0];
      if (req_err) begin
        hold_rdata_d = 32'd0;
        hold_err_d   = 1'b1;
      end
    end else if (state_q == ACC && !rsp_ready) begin
      hold_rdata_d = fmt_rdata;
      hold_err_d   = 1'b0;
    end
  end

  always_comb begin
    rsp_valid = 1'b0;
    rsp_rdata = 32'd0;
    rsp_err   = 1'b0;
    mem_cen   = 1'b1;
    mem_wen   = 1'b1;
    mem_ben   = 4'hF;
    mem_addr  = '0;
    mem_din   = '0;
    case (state_q)
      IDLE: begin
        if (accept && !req_err) begin
          mem_cen  = 1'b0;
          mem_addr = req_addr[AW+1:2];
          if (req_we) begin
            mem_wen = 1'b0;
            case (req_size)
              SZ_BYTE: begin
                mem_din = {4{req_wdata[7:0]}};
                mem_ben = ~(4'b0001 << req_addr[1:0]);
              end
              SZ_HALF: begin
                mem_din = {2{req_wdata[15:0]}};
                mem_ben = ~(4'b0011 << {req_addr[1], 1'b0});
              end
              default: begin
                mem_din = req_wdata;
                mem_ben = 4'h0;
              end
            endcase
          end
        end
      end
      ACC: begin
        rsp_valid = 1'b1;
        rsp_rdata = fmt_rdata;
      end
      HOLD: begin
        rsp_valid = 1'b1;
        rsp_rdata = hold_rdata_q;
        rsp_err   = hold_err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_sram_port.sv
// Directed bench for lsu_sram_port with a behavioural one-cycle-latency
// byte-enabled SRAM model behind the data port.
module tb_lsu_sram_port;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_cen, mem_wen;
  logic [3:0]  mem_ben;
  logic [15:0] mem_addr;
  logic [31:0] mem_din, mem_dout;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] sram [65536];

  always #5 clk = ~clk;

  lsu_sram_port dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_cen(mem_cen),
    .mem_wen(mem_wen), .mem_ben(mem_ben), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // SRAM model: read data appears the cycle after cen is low, else returns 0.
  always @(posedge clk) begin
    if (!mem_cen) begin
      if (!mem_wen)
        for (int b = 0; b < 4; b++)
          if (!mem_ben[b]) sram[mem_addr][8*b +: 8] <= mem_din[8*b +: 8];
      mem_dout <= sram[mem_addr];
    end else begin
      mem_dout <= 32'd0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present one request for a single cycle and check the issue-cycle SRAM pins.
  task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic e_cen, input logic e_wen, input logic [3:0] e_ben,
                        input logic [15:0] e_maddr, input logic [31:0] e_din);
    @(negedge clk);
    req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    #1;
    check({tag, " req_ready"}, 32'(req_ready), 32'd1);
    check({tag, " mem_cen"},   32'(mem_cen),   32'(e_cen));
    check({tag, " mem_wen"},   32'(mem_wen),   32'(e_wen));
    check({tag, " mem_ben"},   32'(mem_ben),   32'(e_ben));
    if (!e_cen) begin
      check({tag, " mem_addr"}, 32'(mem_addr), 32'(e_maddr));
      check({tag, " mem_din"},  mem_din,       e_din);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Called #1 after the accept edge with rsp_ready high: response is due now.
  task automatic do_rsp(input string tag, input logic [31:0] e_rdata, input logic e_err);
    check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, " rsp_rdata"}, rsp_rdata,      e_rdata);
    check({tag, " rsp_err"},   32'(rsp_err),   32'(e_err));
    check({tag, " cen idle"},  32'(mem_cen),   32'd1);
    @(posedge clk); #1;
    check({tag, " done valid"}, 32'(rsp_valid), 32'd0);
    check({tag, " done ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2;
    req_unsigned = 1'b0; req_addr = 32'h100; req_wdata = 32'h1234_5678;
    rsp_ready = 1'b1;
    #1;
    check("rst rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst rsp_err",   32'(rsp_err),   32'd0);
    check("rst rsp_rdata", rsp_rdata,      32'd0);
    check("rst mem_cen",   32'(mem_cen),   32'd1);
    check("rst mem_wen",   32'(mem_wen),   32'd1);
    check("rst mem_ben",   32'(mem_ben),   32'hF);
    check("rst mem_addr",  32'(mem_addr),  32'd0);
    check("rst mem_din",   mem_din,        32'd0);
    repeat (2) @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    check("post-rst req_ready", 32'(req_ready), 32'd1);

    // Word store then word load at 0x100.
    do_req("st_w", 1, 2, 0, 32'h100, 32'hDEAD_BEEF, 0, 0, 4'h0, 16'h40, 32'hDEAD_BEEF);
    do_rsp("st_w", 32'd0, 0);
    do_req("ld_w", 0, 2, 0, 32'h100, 32'd0, 0, 1, 4'hF, 16'h40, 32'd0);
    do_rsp("ld_w", 32'hDEAD_BEEF, 0);

    // Byte store into the top lane, then signed/unsigned byte loads.
    do_req("st_b", 1, 0, 0, 32'h103, 32'h0000_0080, 0, 0, 4'b0111, 16'h40, 32'h8080_8080);
    do_rsp("st_b", 32'd0, 0);
    do_req("ld_bs", 0, 0, 0, 32'h103, 32'd0, 0, 1, 4'hF, 16'h40, 32'd0);
    do_rsp("ld_bs", 32'hFFFF_FF80, 0);
    do_req("ld_bu", 0, 0, 1, 32'h103, 32'd0, 0, 1, 4'hF, 16'h40, 32'd0);
    do_rsp("ld_bu", 32'h0000_0080, 0);
    do_req("ld_w2", 0, 2, 0, 32'h100, 32'd0, 0, 1, 4'hF, 16'h40, 32'd0);
    do_rsp("ld_w2", 32'h80AD_BEEF, 0);

    // Half-word paths on 0x8001_1234 at 0x200.
    do_req("st_w2", 1, 2, 0, 32'h200, 32'h8001_1234, 0, 0, 4'h0, 16'h80, 32'h8001_1234);
    do_rsp("st_w2", 32'd0, 0);
    do_req("ld_hs", 0, 1, 0, 32'h202, 32'd0, 0, 1, 4'hF, 16'h80, 32'd0);
    do_rsp("ld_hs", 32'hFFFF_8001, 0);
    do_req("ld_hu", 0, 1, 1, 32'h200, 32'd0, 0, 1, 4'hF, 16'h80, 32'd0);
    do_rsp("ld_hu", 32'h0000_1234, 0);
    do_req("ld_b1", 0, 0, 0, 32'h201, 32'd0, 0, 1, 4'hF, 16'h80, 32'd0);
    do_rsp("ld_b1", 32'h0000_0012, 0);
    do_req("st_h", 1, 1, 0, 32'h206, 32'h1234_ABCD, 0, 0, 4'b0011, 16'h81, 32'hABCD_ABCD);
    do_rsp("st_h", 32'd0, 0);
    do_req("ld_hu2", 0, 1, 1, 32'h206, 32'd0, 0, 1, 4'hF, 16'h81, 32'd0);
    do_rsp("ld_hu2", 32'h0000_ABCD, 0);

    // Error requests: no SRAM access, rsp_err with zero data.
    do_req("err_h", 0, 1, 0, 32'h101, 32'd0, 1, 1, 4'hF, 16'h0, 32'd0);
    do_rsp("err_h", 32'd0, 1);
    do_req("err_w", 1, 2, 0, 32'h102, 32'hFFFF_FFFF, 1, 1, 4'hF, 16'h0, 32'd0);
    do_rsp("err_w", 32'd0, 1);
    do_req("err_sz", 0, 3, 0, 32'h100, 32'd0, 1, 1, 4'hF, 16'h0, 32'd0);
    do_rsp("err_sz", 32'd0, 1);
    do_req("err_rng", 1, 2, 0, 32'h0004_0000, 32'h5555_5555, 1, 1, 4'hF, 16'h0, 32'd0);
    do_rsp("err_rng", 32'd0, 1);
    do_req("ok_top", 0, 2, 0, 32'h0003_FFFC, 32'd0, 0, 1, 4'hF, 16'hFFFF, 32'd0);
    @(posedge clk); #1;
    check("ok_top done", 32'(rsp_valid), 32'd0);

    // Back-pressure: response must hold while the SRAM output drops to zero.
    rsp_ready = 1'b0;
    do_req("stall", 0, 2, 0, 32'h100, 32'd0, 0, 1, 4'hF, 16'h40, 32'd0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("stall%0d rsp_valid", i), 32'(rsp_valid), 32'd1);
      check($sformatf("stall%0d rsp_rdata", i), rsp_rdata,      32'h80AD_BEEF);
      check($sformatf("stall%0d req_ready", i), 32'(req_ready), 32'd0);
      if (i < 3) begin @(posedge clk); #1; end
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("stall rel valid", 32'(rsp_valid), 32'd0);
    check("stall rel ready", 32'(req_ready), 32'd1);

    // Reset during ACC, with a store held valid that must not reach the SRAM.
    do_req("rst_acc", 0, 2, 0, 32'h100, 32'd0, 0, 1, 4'hF, 16'h40, 32'd0);
    check("rst_acc in ACC", 32'(rsp_valid), 32'd1);
    req_we = 1'b1; req_size = 2'd2; req_addr = 32'h100; req_wdata = 32'd0;
    req_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    check("rst_acc mem_cen",   32'(mem_cen),   32'd1);
    check("rst_acc rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    check("rst_acc req_ready", 32'(req_ready), 32'd1);
    check("rst_acc rsp_valid2", 32'(rsp_valid), 32'd0);
    do_req("ld_after", 0, 2, 0, 32'h100, 32'd0, 0, 1, 4'hF, 16'h40, 32'd0);
    do_rsp("ld_after", 32'h80AD_BEEF, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
